ram_multiport: RTL and testbench

- Parametrised 1-write / N-read word memory.
- Successor to the fixed two-read-port replicated-bank RAM in the datapath (register file / operand memory).
- Adds:
  - a generic read-port count;
  - per-port read enables;
  - write-to-read bypass;
  - a hardware clear sequencer that zeroes the array after reset or on request.
- Sits between the control unit (write port) and the ALU operand fetch (read ports).

---
 rtl/ram_multiport_pkg.sv | 18 +
 rtl/ram_multiport_bank.sv | 41 ++++
 rtl/ram_multiport.sv | 151 +++++++++++++++
 tb/tb_ram_multiport.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_multiport_pkg.sv
// Shared types and helpers for the multi-read-port RAM.
// Optional parity storage is selected with RAM_MULTIPORT_PARITY_EN.
package ram_multiport_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int RD_LAT   = 1;
  localparam int PAR_MAXW = 64;

  // Even parity bit: makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [PAR_MAXW-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ram_multiport_bank.sv
// One 1W/1R synchronous bank with a registered, enabled read port.
// Read-first on a same-address collision; the top module handles bypass.
module ram_bank
  import ram_multiport_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // The array carries no reset so it maps onto block/LUT RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_multiport.sv
// 1-write / NRD-read word memory with write-first bypass and a clear sweeper.
// Define RAM_MULTIPORT_PARITY_EN to store a parity bit and add rd_perr/wr_perr_inject.
module ram_multiport
  import ram_multiport_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    busy,
  input  logic [NRD-1:0]          rd_en,
  input  logic [NRD*AWIDTH-1:0]   rd_addr,
  output logic [NRD*WIDTH-1:0]    rd_data,
  input  logic                    wr_en,
  input  logic [AWIDTH-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
`ifdef RAM_MULTIPORT_PARITY_EN
  input  logic                    wr_perr_inject,
  output logic [NRD-1:0]          rd_perr,
`endif
  output state_e                  dbg_state_o
);

`ifdef RAM_MULTIPORT_PARITY_EN
  localparam int BW = WIDTH + 1;
`else
  localparam int BW = WIDTH;
`endif

  state_e              state_q;
  logic [AWIDTH-1:0]   ptr_q;
  logic                busy_q;

  logic [BW-1:0]       wr_word;
  logic                bank_we;
  logic [AWIDTH-1:0]   bank_waddr;
  logic [BW-1:0]       bank_wdata;

  // Sweep FSM: one address per cycle, last address returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          ptr_q <= ptr_q + AWIDTH'(1);
          if (&ptr_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign dbg_state_o = state_q;

`ifdef RAM_MULTIPORT_PARITY_EN
  assign wr_word = {even_parity(PAR_MAXW'(wr_data)) ^ wr_perr_inject, wr_data};
`else
  assign wr_word = wr_data;
`endif

  // All banks see the same write; the sweep owns the write port while clearing.
  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = wr_addr;
    bank_wdata = wr_word;
    if (state_q == ST_CLEAR) begin
      bank_we    = 1'b1;
      bank_waddr = ptr_q;
      bank_wdata = '0;
    end else if (wr_en) begin
      bank_we = 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AWIDTH-1:0] raddr;
    logic [BW-1:0]     bank_dout;
    logic              fwd_d;
    logic              fwd_q;
    logic [BW-1:0]     fwd_data_d;
    logic [BW-1:0]     fwd_data_q;
    logic [BW-1:0]     word;

    assign raddr = rd_addr[i*AWIDTH +: AWIDTH];

    ram_bank #(
      .DW (BW),
      .AW (AWIDTH)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (bank_we),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata),
      .re_i    (rd_en[i]),
      .raddr_i (raddr),
      .rdata_o (bank_dout)
    );

    // Forwarded value overrides the bank: zero while clearing, wr_word on a collision.
    always_comb begin
      fwd_d      = 1'b0;
      fwd_data_d = '0;
      if (state_q == ST_CLEAR) begin
        fwd_d = 1'b1;
      end else if (wr_en && (raddr == wr_addr)) begin
        fwd_d      = 1'b1;
        fwd_data_d = wr_word;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fwd_q      <= 1'b0;
        fwd_data_q <= '0;
      end else if (rd_en[i]) begin
        fwd_q      <= fwd_d;
        fwd_data_q <= fwd_data_d;
      end
    end

    assign word = fwd_q ? fwd_data_q : bank_dout;
    assign rd_data[i*WIDTH +: WIDTH] = word[WIDTH-1:0];

`ifdef RAM_MULTIPORT_PARITY_EN
    assign rd_perr[i] = word[WIDTH] ^ even_parity(PAR_MAXW'(word[WIDTH-1:0]));
`endif
  end

endmodule

// File: tb/tb_ram_multiport.sv
// Scoreboard bench for ram_multiport (AWIDTH=4, NRD=2); covers RAM_MULTIPORT_PARITY_EN when defined.
// Handshake: reads have no valid strobe; every clock edge driven by step() yields one expected entry.
module tb_ram_multiport;
  import ram_multiport_pkg::*;

  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int N     = 2;
  localparam int DEPTH = 16;
  localparam int EW    = 1 + N + N * W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clr = 1'b0;
  logic           busy;
  logic [N-1:0]   rd_en = '0;
  logic [N*AW-1:0] rd_addr = '0;
  logic [N*W-1:0] rd_data;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [W-1:0]   wr_data = '0;
  state_e         dbg_state;
`ifdef RAM_MULTIPORT_PARITY_EN
  logic           wr_perr_inject = 1'b0;
  logic [N-1:0]   rd_perr;
`endif

  logic [EW-1:0]  exp_q[$];
  logic [EW-1:0]  mon_item;
  int             total = 0;
  int             bad = 0;

  // Reference model: array contents, held per-port outputs, remaining sweep cycles.
  logic [W-1:0]   mem_m[DEPTH];
  logic           mem_p[DEPTH];
  logic [W-1:0]   out_m[N];
  logic           perr_m[N];
  int             busy_rem;

  ram_multiport #(.WIDTH(W), .AWIDTH(AW), .NRD(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (clr),
    .busy           (busy),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
`ifdef RAM_MULTIPORT_PARITY_EN
    .wr_perr_inject (wr_perr_inject),
    .rd_perr        (rd_perr),
`endif
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one entry per clock edge, compared on the following falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_item = exp_q.pop_front();
      check("busy", int'(busy), int'(mon_item[EW-1]));
      check("state", int'(dbg_state), mon_item[EW-1] ? int'(ST_CLEAR) : int'(ST_IDLE));
      for (int i = 0; i < N; i++) begin
        check($sformatf("rd_data%0d", i), int'(rd_data[i*W +: W]), int'(mon_item[i*W +: W]));
`ifdef RAM_MULTIPORT_PARITY_EN
        check($sformatf("rd_perr%0d", i), int'(rd_perr[i]), int'(mon_item[N*W + i]));
`endif
      end
    end
  end

  // ---------------- model + drivers ----------------
  task automatic model_reset();
    busy_rem = DEPTH;
    for (int i = 0; i < N; i++) begin
      out_m[i]  = '0;
      perr_m[i] = 1'b0;
    end
    for (int a = 0; a < DEPTH; a++) begin
      mem_m[a] = '0;
      mem_p[a] = 1'b0;
    end
  endtask

  // Called at negedge+1 (or t=2 at start); returns at negedge+1 after release.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_busy", int'(busy), 1);
`ifdef RAM_MULTIPORT_PARITY_EN
    check("rst_rd_perr", int'(rd_perr), 0);
`endif
    model_reset();
    repeat (cycles) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic c, input logic [N-1:0] re, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input logic we, input logic [AW-1:0] wa,
                      input logic [W-1:0] wd, input logic inj);
    logic [AW-1:0] ad[N];
    logic          inj_e;
    clr     = c;
    rd_en   = re;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
`ifdef RAM_MULTIPORT_PARITY_EN
    wr_perr_inject = inj;
    inj_e = inj;
`else
    inj_e = 1'b0;
`endif
    ad[0] = a0;
    ad[1] = a1;
    if (busy_rem == 0) begin
      for (int i = 0; i < N; i++) begin
        if (re[i]) begin
          if (we && ad[i] == wa) begin
            out_m[i]  = wd;
            perr_m[i] = inj_e;
          end else begin
            out_m[i]  = mem_m[ad[i]];
            perr_m[i] = mem_p[ad[i]];
          end
        end
      end
      if (we) begin
        mem_m[wa] = wd;
        mem_p[wa] = inj_e;
      end
      if (c) begin
        // After a full sweep every word reads as a clean zero; writes meanwhile are lost.
        busy_rem = DEPTH;
        for (int a = 0; a < DEPTH; a++) begin
          mem_m[a] = '0;
          mem_p[a] = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (re[i]) begin
          out_m[i]  = '0;
          perr_m[i] = 1'b0;
        end
      end
      busy_rem--;
    end
    exp_q.push_back({busy_rem != 0, perr_m[1], perr_m[0], out_m[1], out_m[0]});
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    logic          c;
    logic [N-1:0]  re;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic          inj;

    rst_n = 1'b1;
    #2;
    do_reset(3);

    // Sweep after reset: busy for DEPTH edges, then everything reads zero.
    repeat (DEPTH) idle();
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 2'b11, AW'(a), AW'(DEPTH - 1 - a), 1'b0, '0, '0, 1'b0);
    end

    // Basic write then read on both ports.
    step(1'b0, 2'b00, '0, '0, 1'b1, 4'h3, 8'hA5, 1'b0);
    step(1'b0, 2'b11, 4'h3, 4'h3, 1'b0, '0, '0, 1'b0);

    // Write-first bypass on port 0, port 1 sees old contents of 0x08.
    step(1'b0, 2'b00, '0, '0, 1'b1, 4'h8, 8'h55, 1'b0);
    step(1'b0, 2'b11, 4'h7, 4'h8, 1'b1, 4'h7, 8'h3C, 1'b0);
    step(1'b0, 2'b01, 4'h7, '0, 1'b0, '0, '0, 1'b0);

    // Hold with changing addresses.
    step(1'b0, 2'b00, 4'h8, 4'h7, 1'b0, '0, '0, 1'b0);
    step(1'b0, 2'b00, 4'h2, 4'h3, 1'b0, '0, '0, 1'b0);

    // Clear request; a write during the sweep is dropped.
    step(1'b0, 2'b00, '0, '0, 1'b1, 4'h1, 8'h77, 1'b0);
    step(1'b1, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 2'b00, '0, '0, 1'b1, 4'h1, 8'h99, 1'b0);
    repeat (DEPTH - 1) idle();
    step(1'b0, 2'b11, 4'h1, 4'h3, 1'b0, '0, '0, 1'b0);

    // Parity: injected error, clean rewrite, bypass carrying the inject flag.
    step(1'b0, 2'b00, '0, '0, 1'b1, 4'hA, 8'h0F, 1'b1);
    step(1'b0, 2'b01, 4'hA, '0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 2'b00, '0, '0, 1'b1, 4'hA, 8'h0F, 1'b0);
    step(1'b0, 2'b10, '0, 4'hA, 1'b0, '0, '0, 1'b0);
    step(1'b0, 2'b01, 4'hB, '0, 1'b1, 4'hB, 8'hF0, 1'b1);
    step(1'b0, 2'b10, '0, 4'hB, 1'b0, '0, '0, 1'b0);

    // Reset in the middle of a sweep (pointer at 5) with non-zero data on both ports.
    step(1'b0, 2'b00, '0, '0, 1'b1, 4'h3, 8'hA5, 1'b0);
    step(1'b0, 2'b11, 4'h3, 4'h3, 1'b0, '0, '0, 1'b0);
    step(1'b1, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0);
    repeat (5) idle();
    do_reset(2);
    repeat (DEPTH) idle();
    step(1'b0, 2'b11, 4'h3, 4'hA, 1'b0, '0, '0, 1'b0);

    // Randomized traffic with occasional clears.
    for (int k = 0; k < 400; k++) begin
      c   = ($urandom_range(0, 39) == 0);
      re  = N'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      wa  = AW'($urandom_range(0, DEPTH - 1));
      wd  = W'($urandom_range(0, 255));
      inj = ($urandom_range(0, 3) == 0);
      a0  = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      a1  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      step(c, re, a0, a1, we, wa, wd, inj);
    end

    repeat (RD_LAT) idle();
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() > 0) begin
      check("drain", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
